cdb_arbiter: RTL and testbench
==============================

# cdb_arbiter

Common Data Bus arbiter for the Tomasulo core. It collects completed-result requests from all reservation stations and grants the single CDB slot to one station per cycle using round-robin order. It drives the registered CDB broadcast (tag, destination, data) that the register file, `reg_status` clear logic and waiting reservation stations snoop. It sits between the execute stage and the writeback/forwarding logic, and replaces the unbounded all-stations-write-at-once writeback.

## Interface
Parameters:
- `NUM_RS`, 8: number of reservation stations (requesters).
- `DATA_W`, 16: result width.
- `TAG_W`, 5: tag width; tag = station index + 1, 0 = no producer.
- `REG_AW`, 3: destination register index width.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `req`  in  NUM_RS  bit i = station i holds a finished result.
- `req_data`  in  NUM_RS*DATA_W  result of station i at slice i.
- `req_dest`  in  NUM_RS*REG_AW  destination register of station i.
- `req_wr`  in  NUM_RS  1 = result writes a register (0 for store/branch).
- `cdb_ready`  in  1  0 = downstream cannot accept a broadcast this cycle.
- `grant`  out  NUM_RS  registered one-hot grant, at most one bit set.
- `cdb_valid`  out  1  broadcast valid.
- `cdb_tag`  out  TAG_W  tag of the broadcasting station.
- `cdb_data`  out  DATA_W  broadcast result.
- `cdb_dest`  out  REG_AW  destination register.
- `cdb_wr`  out  1  copy of `req_wr` for the granted station.

## Operation
- State: round-robin pointer `ptr` (0..NUM_RS-1), output registers.
- Eligible set: `req & ~grant`. The station granted in the current cycle is masked so it is never granted twice.
- Arbitration: first eligible index at or after `ptr`, in increasing order, wrapping NUM_RS-1 to 0.
- On a clock edge with `cdb_ready`=1 and a non-empty eligible set, winner w:
  - `grant` = 1<<w, `cdb_valid`=1, `cdb_tag`=w+1.
  - `cdb_data`/`cdb_dest`/`cdb_wr` = slices of w.
  - `ptr` = (w+1) mod NUM_RS.
- Eligible set empty: `grant`=0, `cdb_valid`=0, data outputs hold their last value, `ptr` unchanged.
- `cdb_ready`=0: no new grant. `grant`, `cdb_valid` and all CDB outputs hold. `ptr` unchanged.
- Requester contract:
  - Hold `req[i]` and its data stable until `grant[i]` is observed high.
  - Deassert `req[i]` at the next edge.
  - Free the station only after the grant.
- Reset value of every output is 0; `ptr`=0.

## Timing
- Latency: a request sampled at edge k is granted and broadcast at edge k (outputs valid during cycle k to k+1). Minimum request-to-broadcast is 1 cycle; worst case NUM_RS cycles with all stations requesting.
- Throughput: one broadcast per cycle while `cdb_ready`=1.
- A station that deasserts `req` before it is granted is simply not considered; no error is raised.
- `cdb_ready` falling while `cdb_valid`=1: the broadcast is held (repeated) until `cdb_ready` returns. Consumers must treat a held broadcast as idempotent.
- `reset` asserted mid-broadcast: outputs drop to 0 asynchronously and the in-flight grant is lost. Requesters reset at the same time.

## Configuration
- `CDB_PERF_CNT_EN` defined:
  - Adds outputs `perf_bcast` (32 bits), counting cycles with `cdb_valid`=1 and `cdb_ready`=1.
  - Adds `perf_conflict` (32 bits), counting edges where the eligible set had 2 or more bits.
  - Both reset to 0 and saturate at all-ones.
- Not defined: these ports and counters do not exist. Arbitration behaviour is identical either way.

## Structure
- Shared package `tomasulo_pkg`:
  - `NUM_RS`, `DATA_W`, `TAG_W`, `REG_AW`.
  - Opcode localparams (LOAD=0, STORE=1, ADD=2, MUL=3, BEQ=4).
  - A CDB broadcast struct (valid, tag, dest, wr, data), reused by the register file and reservation stations.
- One sub-module, `rr_pick`: combinational rotate / find-first-set / unrotate that returns a valid flag and the winner index from (eligible vector, ptr). All state stays in `cdb_arbiter`.

## Test plan
- Single request: `req`=0x04, data 0x1234, dest 5 -> at the next edge `grant`=0x04, `cdb_tag`=3, `cdb_data`=0x1234, `cdb_dest`=5, `ptr`=3; idle afterwards.
- All 8 stations request and hold until granted, from `ptr`=0 -> grants 0x01, 0x02, … 0x80 on 8 consecutive edges, tags 1..8, no gaps or repeats.
- Wrap: `ptr`=6, `req`=0x41 -> grant 0x40 (tag 7), then 0x01 (tag 1); `ptr` ends at 1.
- Backpressure: `cdb_ready`=0 for 3 cycles while broadcasting tag 2 -> outputs frozen for 3 cycles with no new grant. After `cdb_ready`=1, the next eligible station is granted.
- Async reset during a broadcast of tag 4, asserted between edges -> all outputs 0 before the next edge; after release, `req`=0x10 is granted with tag 5 from `ptr`=0.
- With `CDB_PERF_CNT_EN`: the 8-requester run yields `perf_bcast`=8 and `perf_conflict`=7.

Source files
------------

// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo core definitions: machine sizes, opcodes and the CDB broadcast record.
package tomasulo_pkg;

    localparam int unsigned NUM_RS = 8;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned TAG_W  = 5;
    localparam int unsigned REG_AW = 3;

    localparam logic [2:0] OP_LOAD  = 3'd0;
    localparam logic [2:0] OP_STORE = 3'd1;
    localparam logic [2:0] OP_ADD   = 3'd2;
    localparam logic [2:0] OP_MUL   = 3'd3;
    localparam logic [2:0] OP_BEQ   = 3'd4;

    // One CDB broadcast as seen by the register file and the reservation stations.
    typedef struct packed {
        logic              valid;
        logic [TAG_W-1:0]  tag;
        logic [REG_AW-1:0] dest;
        logic              wr;
        logic [DATA_W-1:0] data;
    } cdb_bcast_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: rotate the request vector so ptr sits at bit 0, find the first set bit,
// then map that offset back to an absolute index. Purely combinational.
module rr_pick #(
    parameter int unsigned N     = 8,
    parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     eligible,
    input  logic [IDX_W-1:0] ptr,
    output logic             valid,
    output logic [IDX_W-1:0] winner
);

    logic [N-1:0]     rotated;
    logic [IDX_W-1:0] first;
    logic [IDX_W:0]   sum;

    // Rotate, find-first-set, unrotate with modulo-N wrap.
    always_comb begin
        rotated = N'({eligible, eligible} >> ptr);
        valid   = |rotated;
        first   = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                first = IDX_W'(i);
            end
        end
        sum = {1'b0, first} + {1'b0, ptr};
        if (sum >= (IDX_W + 1)'(N)) begin
            sum = sum - (IDX_W + 1)'(N);
        end
        winner = sum[IDX_W-1:0];
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: grants one finished reservation station per cycle in round-robin
// order and drives the registered CDB broadcast.
// Optional: define CDB_PERF_CNT_EN to add the perf_bcast / perf_conflict saturating counters.
module cdb_arbiter #(
    parameter int unsigned NUM_RS = tomasulo_pkg::NUM_RS,
    parameter int unsigned DATA_W = tomasulo_pkg::DATA_W,
    parameter int unsigned TAG_W  = tomasulo_pkg::TAG_W,
    parameter int unsigned REG_AW = tomasulo_pkg::REG_AW
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RS-1:0]        req,
    input  logic [NUM_RS*DATA_W-1:0] req_data,
    input  logic [NUM_RS*REG_AW-1:0] req_dest,
    input  logic [NUM_RS-1:0]        req_wr,
    input  logic                     cdb_ready,
    output logic [NUM_RS-1:0]        grant,
    output logic                     cdb_valid,
    output logic [TAG_W-1:0]         cdb_tag,
    output logic [DATA_W-1:0]        cdb_data,
    output logic [REG_AW-1:0]        cdb_dest,
    output logic                     cdb_wr
`ifdef CDB_PERF_CNT_EN
    ,
    output logic [31:0]              perf_bcast,
    output logic [31:0]              perf_conflict
`endif
);

    localparam int unsigned IDX_W = (NUM_RS > 1) ? $clog2(NUM_RS) : 1;

    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [NUM_RS-1:0] grant_q, grant_d;
    logic              valid_q, valid_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [REG_AW-1:0] dest_q, dest_d;
    logic              wr_q, wr_d;

    logic [NUM_RS-1:0] elig;
    logic              pick_valid;
    logic [IDX_W-1:0]  winner;

    // The station currently on the bus is masked so a lingering req is not granted twice.
    assign elig = req & ~grant_q;

    rr_pick #(
        .N     (NUM_RS),
        .IDX_W (IDX_W)
    ) u_pick (
        .eligible (elig),
        .ptr      (ptr_q),
        .valid    (pick_valid),
        .winner   (winner)
    );

    // Next-state: hold everything under backpressure, drop grant when nobody is eligible.
    always_comb begin
        ptr_d   = ptr_q;
        grant_d = grant_q;
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        dest_d  = dest_q;
        wr_d    = wr_q;
        if (cdb_ready) begin
            if (pick_valid) begin
                grant_d = NUM_RS'(1) << winner;
                valid_d = 1'b1;
                tag_d   = TAG_W'(winner) + TAG_W'(1);
                for (int i = 0; i < int'(NUM_RS); i++) begin
                    if (winner == IDX_W'(i)) begin
                        data_d = req_data[i*DATA_W +: DATA_W];
                        dest_d = req_dest[i*REG_AW +: REG_AW];
                        wr_d   = req_wr[i];
                    end
                end
                ptr_d = (winner == IDX_W'(NUM_RS - 1)) ? '0 : winner + IDX_W'(1);
            end else begin
                grant_d = '0;
                valid_d = 1'b0;
            end
        end
    end

    // Pointer and broadcast registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q   <= '0;
            grant_q <= '0;
            valid_q <= 1'b0;
            tag_q   <= '0;
            data_q  <= '0;
            dest_q  <= '0;
            wr_q    <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            valid_q <= valid_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
            dest_q  <= dest_d;
            wr_q    <= wr_d;
        end
    end

    assign grant     = grant_q;
    assign cdb_valid = valid_q;
    assign cdb_tag   = tag_q;
    assign cdb_data  = data_q;
    assign cdb_dest  = dest_q;
    assign cdb_wr    = wr_q;

`ifdef CDB_PERF_CNT_EN
    logic [31:0] perf_bcast_q;
    logic [31:0] perf_conflict_q;
    logic        multi_elig;

    // Two or more eligible bits: clearing the lowest set bit leaves something behind.
    assign multi_elig = |(elig & (elig - NUM_RS'(1)));

    // Saturating counters for accepted broadcasts and arbitration conflicts.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_bcast_q    <= '0;
            perf_conflict_q <= '0;
        end else begin
            if (valid_q && cdb_ready && !(&perf_bcast_q)) begin
                perf_bcast_q <= perf_bcast_q + 32'd1;
            end
            if (multi_elig && !(&perf_conflict_q)) begin
                perf_conflict_q <= perf_conflict_q + 32'd1;
            end
        end
    end

    assign perf_bcast    = perf_bcast_q;
    assign perf_conflict = perf_conflict_q;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios plus a randomized run, all checked
// against a round-robin reference model kept in this file.
module tb_cdb_arbiter;

    logic         clk;
    logic         reset;
    logic [7:0]   req;
    logic [127:0] req_data;
    logic [23:0]  req_dest;
    logic [7:0]   req_wr;
    logic         cdb_ready;
    logic [7:0]   grant;
    logic         cdb_valid;
    logic [4:0]   cdb_tag;
    logic [15:0]  cdb_data;
    logic [2:0]   cdb_dest;
    logic         cdb_wr;
`ifdef CDB_PERF_CNT_EN
    logic [31:0]  perf_bcast;
    logic [31:0]  perf_conflict;
`endif

    // Per-station requester state.
    logic [15:0] st_data [8];
    logic [2:0]  st_dest [8];
    logic        st_wr   [8];

    // Reference model state.
    int          m_ptr;
    logic [7:0]  m_grant;
    logic        m_valid;
    logic [4:0]  m_tag;
    logic [15:0] m_data;
    logic [2:0]  m_dest;
    logic        m_wr;

    int n_checks;
    int n_fail;

    wire [33:0] obs = {grant, cdb_valid, cdb_tag, cdb_data, cdb_dest, cdb_wr};
    wire [33:0] mdl = {m_grant, m_valid, m_tag, m_data, m_dest, m_wr};

    cdb_arbiter u_dut (
        .clk           (clk),
        .reset         (reset),
        .req           (req),
        .req_data      (req_data),
        .req_dest      (req_dest),
        .req_wr        (req_wr),
        .cdb_ready     (cdb_ready),
        .grant         (grant),
        .cdb_valid     (cdb_valid),
        .cdb_tag       (cdb_tag),
        .cdb_data      (cdb_data),
        .cdb_dest      (cdb_dest),
        .cdb_wr        (cdb_wr)
`ifdef CDB_PERF_CNT_EN
        ,
        .perf_bcast    (perf_bcast),
        .perf_conflict (perf_conflict)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        req_data = '0;
        req_dest = '0;
        req_wr   = '0;
        for (int i = 0; i < 8; i++) begin
            req_data[i*16 +: 16] = st_data[i];
            req_dest[i*3 +: 3]   = st_dest[i];
            req_wr[i]            = st_wr[i];
        end
    end

    task automatic model_reset();
        m_ptr   = 0;
        m_grant = '0;
        m_valid = 1'b0;
        m_tag   = '0;
        m_data  = '0;
        m_dest  = '0;
        m_wr    = 1'b0;
    endtask

    // One clock: decide the winner from the rules, advance the model, then let granted
    // requesters drop their request as the contract asks.
    task automatic tick();
        logic [7:0] elig;
        logic [7:0] sh;
        logic [2:0] j;
        int         w;
        elig = req & ~m_grant;
        w    = -1;
        for (int k = 0; k < 8; k++) begin
            j  = 3'((m_ptr + k) % 8);
            sh = elig >> j;
            if (w < 0 && sh[0]) w = int'(j);
        end
        @(posedge clk);
        if (cdb_ready) begin
            if (w >= 0) begin
                j       = 3'(w);
                m_grant = 8'd1 << j;
                m_valid = 1'b1;
                m_tag   = 5'(w + 1);
                m_data  = st_data[j];
                m_dest  = st_dest[j];
                m_wr    = st_wr[j];
                m_ptr   = (w + 1) % 8;
            end else begin
                m_grant = '0;
                m_valid = 1'b0;
            end
        end
        #1;
        req = req & ~m_grant;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        req   = '0;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        pulse_reset();
        n_checks++;
        if (obs !== 34'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h want 0", obs);
        end
        n_checks++;
        if (u_dut.ptr_q !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_ptr: got %0d want 0", u_dut.ptr_q);
        end
    endtask

    task automatic test_single();
        st_data[2] = 16'h1234;
        st_dest[2] = 3'd5;
        st_wr[2]   = 1'b1;
        req        = 8'h04;
        tick();
        n_checks++;
        if (obs !== {8'h04, 1'b1, 5'd3, 16'h1234, 3'd5, 1'b1}) begin
            n_fail++;
            $display("FAIL single_grant: got %h want %h", obs,
                     {8'h04, 1'b1, 5'd3, 16'h1234, 3'd5, 1'b1});
        end
        n_checks++;
        if (u_dut.ptr_q !== 3'd3) begin
            n_fail++;
            $display("FAIL single_ptr: got %0d want 3", u_dut.ptr_q);
        end
        tick();
        n_checks++;
        if (obs !== {8'h00, 1'b0, 5'd3, 16'h1234, 3'd5, 1'b1}) begin
            n_fail++;
            $display("FAIL single_idle: got %h want %h", obs,
                     {8'h00, 1'b0, 5'd3, 16'h1234, 3'd5, 1'b1});
        end
    endtask

    task automatic test_all_stations();
        pulse_reset();
        for (int i = 0; i < 8; i++) begin
            st_data[i] = 16'($urandom);
            st_dest[i] = 3'($urandom);
            st_wr[i]   = 1'($urandom);
        end
        req = 8'hff;
        for (int i = 0; i < 8; i++) begin
            tick();
            n_checks++;
            if (grant !== (8'd1 << i) || cdb_tag !== 5'(i + 1) || obs !== mdl) begin
                n_fail++;
                $display("FAIL all_req_step%0d: got %h want %h", i, obs, mdl);
            end
        end
        tick();
        n_checks++;
        if (obs !== mdl || u_dut.ptr_q !== 3'd0) begin
            n_fail++;
            $display("FAIL all_req_drain: got %h ptr %0d want %h ptr 0", obs, u_dut.ptr_q, mdl);
        end
`ifdef CDB_PERF_CNT_EN
        n_checks++;
        if (perf_bcast !== 32'd8 || perf_conflict !== 32'd7) begin
            n_fail++;
            $display("FAIL perf_counts: got bcast %0d conflict %0d want 8 7",
                     perf_bcast, perf_conflict);
        end
`endif
    endtask

    task automatic test_wrap();
        // Grant station 5 alone so the pointer lands on 6.
        req = 8'h20;
        tick();
        tick();
        n_checks++;
        if (u_dut.ptr_q !== 3'd6) begin
            n_fail++;
            $display("FAIL wrap_setup_ptr: got %0d want 6", u_dut.ptr_q);
        end
        req = 8'h41;
        tick();
        n_checks++;
        if (grant !== 8'h40 || cdb_tag !== 5'd7 || obs !== mdl) begin
            n_fail++;
            $display("FAIL wrap_first: got %h want %h", obs, mdl);
        end
        tick();
        n_checks++;
        if (grant !== 8'h01 || cdb_tag !== 5'd1 || obs !== mdl || u_dut.ptr_q !== 3'd1) begin
            n_fail++;
            $display("FAIL wrap_second: got %h ptr %0d want %h ptr 1", obs, u_dut.ptr_q, mdl);
        end
        tick();
    endtask

    task automatic test_backpressure();
        // Pointer is 1 here, so station 1 (tag 2) wins first.
        req = 8'h0a;
        tick();
        n_checks++;
        if (cdb_tag !== 5'd2 || obs !== mdl) begin
            n_fail++;
            $display("FAIL bp_first: got %h want %h", obs, mdl);
        end
        cdb_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_checks++;
            if (grant !== 8'h02 || cdb_tag !== 5'd2 || obs !== mdl) begin
                n_fail++;
                $display("FAIL bp_hold%0d: got %h want %h", c, obs, mdl);
            end
        end
        cdb_ready = 1'b1;
        tick();
        n_checks++;
        if (grant !== 8'h08 || cdb_tag !== 5'd4 || obs !== mdl) begin
            n_fail++;
            $display("FAIL bp_resume: got %h want %h", obs, mdl);
        end
    endtask

    task automatic test_async_reset();
        // Station 3 (tag 4) is on the bus from the previous scenario.
        n_checks++;
        if (cdb_valid !== 1'b1 || cdb_tag !== 5'd4) begin
            n_fail++;
            $display("FAIL areset_setup: got valid %b tag %0d want 1 4", cdb_valid, cdb_tag);
        end
        #2;
        reset = 1'b1;
        req   = '0;
        model_reset();
        #1;
        n_checks++;
        if (obs !== 34'd0 || u_dut.ptr_q !== 3'd0) begin
            n_fail++;
            $display("FAIL areset_clear: got %h ptr %0d want 0", obs, u_dut.ptr_q);
        end
        #2;
        reset = 1'b0;
        st_data[4] = 16'hbeef;
        st_dest[4] = 3'd2;
        st_wr[4]   = 1'b0;
        req        = 8'h10;
        tick();
        n_checks++;
        if (grant !== 8'h10 || cdb_tag !== 5'd5 || obs !== mdl) begin
            n_fail++;
            $display("FAIL areset_after: got %h want %h", obs, mdl);
        end
    endtask

    task automatic test_random();
        logic [7:0] bit_i;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 8; i++) begin
                bit_i = req >> i;
                if (!bit_i[0] && $urandom_range(0, 2) == 0) begin
                    st_data[i] = 16'($urandom);
                    st_dest[i] = 3'($urandom);
                    st_wr[i]   = 1'($urandom);
                    req        = req | (8'd1 << i);
                end
            end
            cdb_ready = ($urandom_range(0, 3) != 0);
            tick();
            n_checks++;
            if (obs !== mdl) begin
                n_fail++;
                $display("FAIL random_cycle%0d: got %h want %h", c, obs, mdl);
            end
        end
        cdb_ready = 1'b1;
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        reset     = 1'b1;
        req       = '0;
        cdb_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            st_data[i] = '0;
            st_dest[i] = '0;
            st_wr[i]   = 1'b0;
        end
        model_reset();
        test_reset();
        test_single();
        test_all_stations();
        test_wrap();
        test_backpressure();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
